// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result path: opcode enum, flag bit
// positions, the packed queue entry, and the tournament win patterns.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD     = 4'd0,
        SUB     = 4'd1,
        MUL     = 4'd2,
        DIV     = 4'd3,
        NOT     = 4'd4,
        OR      = 4'd5,
        AND     = 4'd6,
        XOR     = 4'd7,
        LSL     = 4'd8,
        LSR     = 4'd9,
        ASR     = 4'd10,
        ROL     = 4'd11,
        ROR     = 4'd12,
        PLIGERO = 4'd13,
        PPESADO = 4'd14,
        PMIXTO  = 4'd15
    } alu_op_e;

    localparam int FLG_ARITH = 8;
    localparam int FLG_LOGIC = 7;
    localparam int FLG_SHIFT = 6;
    localparam int FLG_TOURN = 5;
    localparam int FLG_Z     = 4;
    localparam int FLG_N     = 3;
    localparam int FLG_C     = 2;
    localparam int FLG_V     = 1;
    localparam int FLG_DZ    = 0;

    typedef struct packed {
        alu_op_e     op;
        logic [7:0]  data;
        logic [8:0]  flag;
    } alu_result_t;

    localparam logic [7:0] WIN_A = 8'h00;
    localparam logic [7:0] WIN_B = 8'hFF;

    // A tournament entry scores only on the two exact win patterns.
    function automatic logic is_win(input logic [8:0] flag, input logic [7:0] data,
                                    input logic [7:0] pattern);
        return flag[FLG_TOURN] && (data == pattern);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry sits in a register so the read
// side is fully registered; there is no write-to-read bypass.
module sync_fifo #(
    parameter int WIDTH = 21,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid_i,
    input  logic [WIDTH-1:0] wr_data_i,
    output logic             wr_ready_o,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [LW-1:0]    level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [LW-1:0]    remain;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             push, pop;

    assign wr_ready_o = (level_q != LW'(DEPTH));
    assign push       = wr_valid_i && wr_ready_o;
    assign pop        = valid_q && rd_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        remain   = level_q - LW'(pop);
        level_d  = remain + LW'(push);
        valid_d  = (level_d != '0);
        head_d   = head_q;
        // Entries already in storage take precedence; only an empty queue
        // loads the incoming word straight into the head register.
        if (remain != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (push) begin
            head_d = wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign rd_valid_o = valid_q;
    assign rd_data_o  = head_q;
    assign level_o    = level_q;

endmodule

// File: rtl/alu_result_queue.sv
// ALU result buffer: FIFO of {op, data, flag} with sticky status flags and a
// saturating win tally for the tournament opcodes.
module alu_result_queue
    import alu_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0]             in_op,
    input  logic [7:0]             in_data,
    input  logic [8:0]             in_flag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_op,
    output logic [7:0]             out_data,
    output logic [8:0]             out_flag,
    output logic [$clog2(DEPTH):0] level,
    output logic [4:0]             sticky_flag,
    input  logic                   sticky_clr,
    output logic [CNT_W-1:0]       wins_a,
    output logic [CNT_W-1:0]       wins_b,
    input  logic                   win_clr
);

    alu_result_t      wr_entry, head;
    logic             push;
    logic [4:0]       sticky_q, sticky_d;
    logic [CNT_W-1:0] wins_a_q, wins_a_d;
    logic [CNT_W-1:0] wins_b_q, wins_b_d;

    assign wr_entry = '{op: alu_op_e'(in_op), data: in_data, flag: in_flag};

    sync_fifo #(
        .WIDTH ($bits(alu_result_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_valid_i (in_valid),
        .wr_data_i  (wr_entry),
        .wr_ready_o (in_ready),
        .rd_valid_o (out_valid),
        .rd_ready_i (out_ready),
        .rd_data_o  (head),
        .level_o    (level)
    );

    assign push = in_valid && in_ready;

    always_comb begin
        sticky_d = (sticky_clr ? 5'd0 : sticky_q) | (push ? in_flag[FLG_Z:FLG_DZ] : 5'd0);

        wins_a_d = wins_a_q;
        wins_b_d = wins_b_q;
        // Clear wins over a same-cycle increment; counters stick at all-ones.
        if (win_clr) begin
            wins_a_d = '0;
            wins_b_d = '0;
        end else if (push) begin
            if (is_win(in_flag, in_data, WIN_A) && (wins_a_q != '1)) begin
                wins_a_d = wins_a_q + 1'b1;
            end
            if (is_win(in_flag, in_data, WIN_B) && (wins_b_q != '1)) begin
                wins_b_d = wins_b_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky_q <= '0;
            wins_a_q <= '0;
            wins_b_q <= '0;
        end else begin
            sticky_q <= sticky_d;
            wins_a_q <= wins_a_d;
            wins_b_q <= wins_b_d;
        end
    end

    assign out_op      = head.op;
    assign out_data    = head.data;
    assign out_flag    = head.flag;
    assign sticky_flag = sticky_q;
    assign wins_a      = wins_a_q;
    assign wins_b      = wins_b_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Bench for alu_result_queue: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model.
module tb_alu_result_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [7:0]       in_data;
    logic [8:0]       in_flag;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_op;
    logic [7:0]       out_data;
    logic [8:0]       out_flag;
    logic [LW-1:0]    level;
    logic [4:0]       sticky_flag;
    logic             sticky_clr;
    logic [CNT_W-1:0] wins_a;
    logic [CNT_W-1:0] wins_b;
    logic             win_clr;

    alu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_data     (in_data),
        .in_flag     (in_flag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_op      (out_op),
        .out_data    (out_data),
        .out_flag    (out_flag),
        .level       (level),
        .sticky_flag (sticky_flag),
        .sticky_clr  (sticky_clr),
        .wins_a      (wins_a),
        .wins_b      (wins_b),
        .win_clr     (win_clr)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [20:0] mq[$];
    logic [4:0]  m_sticky;
    int          m_wa, m_wb;
    bit          m_zero_out;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: predict from pre-edge inputs, then compare just after the edge.
    task automatic cyc();
        bit push, pop;
        chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
        push = in_valid && (mq.size() != DEPTH);
        pop  = out_ready && (mq.size() != 0);
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_sticky   = 5'd0;
            m_wa       = 0;
            m_wb       = 0;
            m_zero_out = 1'b1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({in_op, in_data, in_flag});
                m_zero_out = 1'b0;
            end
            m_sticky = (sticky_clr ? 5'd0 : m_sticky) | (push ? in_flag[4:0] : 5'd0);
            if (win_clr) begin
                m_wa = 0;
                m_wb = 0;
            end else if (push && in_flag[5]) begin
                if (in_data == 8'h00 && m_wa < CMAX) m_wa++;
                if (in_data == 8'hFF && m_wb < CMAX) m_wb++;
            end
        end
        #1;
        chk("level", 32'(level), 32'(mq.size()));
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("sticky", 32'(sticky_flag), 32'(m_sticky));
        chk("wins_a", 32'(wins_a), 32'(m_wa));
        chk("wins_b", 32'(wins_b), 32'(m_wb));
        if (mq.size() != 0)
            chk("head", 32'({out_op, out_data, out_flag}), 32'(mq[0]));
        else if (m_zero_out)
            chk("head_after_reset", 32'({out_op, out_data, out_flag}), 32'd0);
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] d,
                         input logic [8:0] f);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_flag  = f;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) cyc();
    endtask

    initial begin
        int  exp_d;
        bit  acc, stall;
        int  bias;

        reset = 1'b1; sticky_clr = 1'b0; win_clr = 1'b0; out_ready = 1'b0;
        drive(1'b0, 4'd0, 8'd0, 9'd0);
        m_sticky = 5'd0; m_wa = 0; m_wb = 0; m_zero_out = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        cyc();

        // First push is visible one cycle later
        drive(1'b1, 4'd0, 8'h05, 9'h100);
        cyc();
        in_valid = 1'b0;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'h05);
        chk("t1_level", 32'(level), 32'd1);
        chk("t1_sticky", 32'(sticky_flag), 32'd0);
        drain();

        // Fill past full with the consumer stalled, then drain in order
        out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 4'(i), 8'(i), 9'd0);
            cyc();
            if (i == 8) chk("full_ready", 32'(in_ready), 32'd0);
        end
        cyc();
        chk("full_level", 32'(level), 32'd8);
        out_ready = 1'b1;
        exp_d = 1;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) begin
                chk("order", 32'(out_data), 32'(exp_d));
                exp_d++;
            end
            acc = in_valid && in_ready;
            cyc();
            if (acc) in_valid = 1'b0;
        end
        chk("drained_count", 32'(exp_d), 32'd10);
        chk("drained_level", 32'(level), 32'd0);

        // Simultaneous push and pop at level 3
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd1, 8'(8'h30 + i), 9'd0);
            cyc();
        end
        drive(1'b1, 4'd2, 8'h40, 9'd0);
        out_ready = 1'b1;
        cyc();
        chk("pushpop_level", 32'(level), 32'd3);
        chk("pushpop_head", 32'(out_data), 32'h31);
        drain();

        // Sticky flags
        sticky_clr = 1'b1; cyc(); sticky_clr = 1'b0;
        drive(1'b1, 4'd0, 8'h00, 9'h110); cyc();
        drive(1'b1, 4'd0, 8'h01, 9'h104); cyc();
        in_valid = 1'b0; cyc();
        chk("sticky_or", 32'(sticky_flag), 32'b10100);
        drive(1'b1, 4'd1, 8'h02, 9'h102); sticky_clr = 1'b1; cyc();
        sticky_clr = 1'b0; in_valid = 1'b0;
        chk("sticky_clr_push", 32'(sticky_flag), 32'b00010);
        drain();

        // Tournament tally
        win_clr = 1'b1; cyc(); win_clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'd14, 8'hFF, 9'h028); cyc();
        end
        drive(1'b1, 4'd13, 8'h00, 9'h020); cyc();
        in_valid = 1'b0; cyc();
        chk("wins_b3", 32'(wins_b), 32'd3);
        chk("wins_a1", 32'(wins_a), 32'd1);
        drive(1'b1, 4'd15, 8'h00, 9'h020); win_clr = 1'b1; cyc();
        win_clr = 1'b0; in_valid = 1'b0;
        chk("win_clr_prio", 32'(wins_a), 32'd0);
        drain();

        // Random traffic; inputs held while stalled
        stall = 1'b0;
        bias  = 1;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) bias = $urandom_range(0, 3);
            if (!stall) begin
                in_valid = ($urandom_range(0, 3) < 3 - (bias == 3 ? 2 : 0));
                in_op    = 4'($urandom);
                case ($urandom_range(0, 3))
                    0:       in_data = 8'h00;
                    1:       in_data = 8'hFF;
                    default: in_data = 8'($urandom);
                endcase
                in_flag = 9'($urandom);
            end
            out_ready  = ($urandom_range(0, 3) < bias + (bias == 0 ? 1 : 0));
            sticky_clr = ($urandom_range(0, 15) == 0);
            win_clr    = ($urandom_range(0, 63) == 0);
            stall = in_valid && !in_ready;
            cyc();
        end
        sticky_clr = 1'b0; win_clr = 1'b0;
        drain();

        // Counter saturation
        win_clr = 1'b1; cyc(); win_clr = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 4'd14, 8'hFF, 9'h020);
        for (int i = 0; i < CMAX + 5; i++) cyc();
        in_valid = 1'b0; cyc();
        chk("wins_b_sat", 32'(wins_b), 32'(CMAX));
        drain();

        // Mid-operation reset with a push pending
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'd3, 8'(8'hA0 + i), 9'h01F); cyc();
        end
        chk("pre_reset_level", 32'(level), 32'd5);
        reset = 1'b1; cyc();
        reset = 1'b0; in_valid = 1'b0;
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'({out_op, out_data, out_flag}), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_sticky", 32'(sticky_flag), 32'd0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_queue.md
# alu_result_queue

Downstream stage of the 8-bit ALU. Each cycle the ALU presents an opcode, an 8-bit result and a 9-bit flag word; this block buffers them in a small FIFO behind a valid/ready handshake. It also keeps sticky status flags and a tournament win tally for the three tournament opcodes. A consumer, such as a display/UART driver or the register writeback, drains the queue at its own pace.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- CNT_W, 8: width of the saturating win counters.

Ports:
- clk  in  1  Single clock, rising edge.
- reset  in  1  Synchronous, active-high.
- in_valid  in  1  The ALU result is valid this cycle.
- in_ready  out  1  The queue can accept an entry (= not full).
- in_op  in  4  ALU opcode (0 ADD … 15 PMIXTO).
- in_data  in  8  ALU result.
- in_flag  in  9  ALU flag word: [8] arith, [7] logic, [6] shift, [5] tournament, [4] Z, [3] N, [2] C, [1] V, [0] DZ.
- out_valid  out  1  The head entry is available.
- out_ready  in  1  The consumer takes the head this cycle.
- out_op  out  4  Head opcode.
- out_data  out  8  Head result.
- out_flag  out  9  Head flag word.
- level  out  $clog2(DEPTH)+1  Current occupancy.
- sticky_flag  out  5  OR-accumulated {Z,N,C,V,DZ} of accepted entries.
- sticky_clr  in  1  Clears sticky_flag.
- wins_a  out  CNT_W  Tournament results won by fighter A.
- wins_b  out  CNT_W  Tournament results won by fighter B.
- win_clr  in  1  Clears both win counters.

## Operation
- Push happens when in_valid && in_ready. Pop happens when out_valid && out_ready.
- in_ready = (level != DEPTH). It does not depend on out_ready: a full queue refuses a push even in a cycle where it pops.
- The FIFO is show-ahead. out_op/out_data/out_flag always reflect the head entry while out_valid=1. They hold their value until popped. They are don't-care when out_valid=0, but are driven to 0 after reset.
- Simultaneous push and pop with 0 < level < DEPTH: level is unchanged, and order is preserved.
- Pointers wrap modulo DEPTH. level counts 0..DEPTH inclusive.
- Sticky flags:
  - Next value = (sticky_clr ? 0 : sticky_flag) | (push ? in_flag[4:0] : 0).
  - So a clear in the same cycle as a push leaves exactly the pushed flags.
- Tournament tally, on push with in_flag[5]=1:
  - in_data==8'h00 increments wins_a.
  - in_data==8'hFF increments wins_b.
  - Any other value is ignored.
  - Counters saturate at 2^CNT_W−1.
  - win_clr has priority over an increment in the same cycle; the result is 0.
- Popping does not affect the sticky flags or the win counters.
- Protocol contract: in_* must hold stable while in_valid && !in_ready. The block does not check this.

## Timing
- Reset (synchronous, dominant over all other inputs):
  - level=0, out_valid=0, in_ready=1.
  - out_op/out_data/out_flag=0.
  - sticky_flag=0, wins_a=wins_b=0.
  - Pointers=0.
- A reset mid-operation discards every queued entry.
- Latency: an entry pushed in cycle N is visible at the output with out_valid=1 in cycle N+1 when the queue was empty. Otherwise it appears in the cycle after all earlier entries have been popped.
- Pushing into an empty queue while the consumer holds out_ready=1: the pop happens in N+1, not N. There is no combinational bypass.
- level, sticky_flag, wins_a and wins_b update in cycle N+1 after the triggering push or pop.
- All outputs are registered except in_ready, which is decoded combinationally from the registered level.
- Throughput is one push and one pop per cycle.

## Structure
- Package alu_pkg holds:
  - The opcode enum alu_op_e (ADD=0, SUB=1, MUL=2, DIV=3, NOT=4, OR=5, AND=6, XOR=7, LSL=8, LSR=9, ASR=10, ROL=11, ROR=12, PLIGERO=13, PPESADO=14, PMIXTO=15).
  - Flag bit-index constants FLG_ARITH..FLG_DZ.
  - The packed struct alu_result_t {op, data, flag}, 21 bits.
  - Constants WIN_A=8'h00 and WIN_B=8'hFF.
- Sub-module sync_fifo is parameterised on width and depth: storage array, pointers, level, show-ahead head register.
- The top level adds the sticky-flag and tally logic around sync_fifo.

## Test plan
- Reset, then push {ADD, 8'h05, 9'h100} at cycle 1 -> out_valid=1 at cycle 2, out_data=8'h05, level=1, sticky_flag=0.
- Hold out_ready=0 and push 9 entries with data 1..9 (DEPTH=8) -> in_ready falls after the 8th, the 9th is held, level=8. Then pop continuously -> data 1..9 come out in order, and level returns to 0.
- At level=3, push and pop in the same cycle -> level stays 3, and the output order is intact.
- Push flag 9'h110 (Z), then 9'h104 (C) -> sticky_flag=5'b10100. Assert sticky_clr together with a push of 9'h102 -> sticky_flag=5'b00010.
- Push {PPESADO, 8'hFF, 9'h028} three times and {PLIGERO, 8'h00, 9'h020} once -> wins_b=3, wins_a=1. Push {PMIXTO, 8'h00, 9'h020} with win_clr=1 -> wins_a=0.
- Fill to level 5, assert reset for 1 cycle -> next cycle level=0, out_valid=0, outputs 0, in_ready=1.
